// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the instruction memory handshake and feeds a single-entry slot to decode.
// Define FETCH_DELAY_SLOT_EN to keep the branch delay-slot instruction instead of flushing it on a redirect.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ZERO_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] jr_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        flush
);

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  typedef enum logic [1:0] {BOOT, REQ, WAIT, DRAIN} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pend_pc, pend_pc_n;
  logic        inst_valid_n;
  logic [31:0] inst_n, inst_pc_n;
  logic        buf_valid, buf_valid_n;
  logic [31:0] buf_inst, buf_inst_n, buf_pc, buf_pc_n;
  logic        req_q;
  logic        ack_ok, redirect, slot_free, keep_ack;
  logic [31:0] target_raw, target;

  assign imem_req  = ~reset & ((state == REQ) | (state == DRAIN));
  assign imem_addr = pc;
  assign ack_ok    = imem_req & imem_ack & ((ZERO_WAIT != 0) | req_q);
  assign redirect  = redirect_valid & (pcsrc != 2'b11);
  assign slot_free = ~inst_valid | ~stall;
  // Without a delay slot, data returning in DRAIN belongs to the killed path.
  assign keep_ack  = ack_ok & (DELAY_SLOT | (state == REQ));
  assign target    = {target_raw[31:2], 2'b00};

  always_comb begin
    target_raw = branch_target;
    case (pcsrc)
      2'b00:   target_raw = jr_target;
      2'b01:   target_raw = jump_target;
      default: target_raw = branch_target;
    endcase
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pend_pc_n    = pend_pc;
    inst_valid_n = inst_valid;
    inst_n       = inst;
    inst_pc_n    = inst_pc;
    buf_valid_n  = buf_valid;
    buf_inst_n   = buf_inst;
    buf_pc_n     = buf_pc;
    flush        = 1'b0;

    // The skid entry catches the one ack that can land while the slot is stalled.
    if (slot_free) begin
      if (buf_valid) begin
        inst_valid_n = 1'b1;
        inst_n       = buf_inst;
        inst_pc_n    = buf_pc;
        buf_valid_n  = 1'b0;
      end else if (keep_ack) begin
        inst_valid_n = 1'b1;
        inst_n       = imem_rdata;
        inst_pc_n    = pc;
      end else begin
        inst_valid_n = 1'b0;
      end
    end
    if (keep_ack && !(slot_free && !buf_valid)) begin
      buf_valid_n = 1'b1;
      buf_inst_n  = imem_rdata;
      buf_pc_n    = pc;
    end

    case (state)
      BOOT: state_n = REQ;
      REQ: begin
        if (ack_ok) begin
          pc_n    = pc + 32'd4;
          state_n = buf_valid_n ? WAIT : REQ;
        end
      end
      WAIT: begin
        if (slot_free) state_n = REQ;
      end
      DRAIN: begin
        if (ack_ok) begin
          pc_n    = pend_pc;
          state_n = buf_valid_n ? WAIT : REQ;
        end
      end
      default: state_n = BOOT;
    endcase

    // An unacked request must finish at its address, so the target waits in pend_pc.
    if (redirect && !reset) begin
      if (imem_req && !ack_ok) begin
        pend_pc_n = target;
        state_n   = DRAIN;
      end else begin
        pc_n = target;
        if (!DELAY_SLOT) state_n = REQ;
      end
      if (!DELAY_SLOT) begin
        flush        = 1'b1;
        inst_valid_n = 1'b0;
        buf_valid_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      pend_pc    <= 32'h0;
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      buf_valid  <= 1'b0;
      buf_inst   <= 32'h0;
      buf_pc     <= 32'h0;
      req_q      <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pend_pc    <= pend_pc_n;
      inst_valid <= inst_valid_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      buf_valid  <= buf_valid_n;
      buf_inst   <= buf_inst_n;
      buf_pc     <= buf_pc_n;
      req_q      <= imem_req;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer; memory returns addr ^ 32'hDEAD_0000 combinationally.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [1:0]  pcsrc;
  logic [31:0] jr_target, jump_target, branch_target;
  logic        stall;
  logic        imem_req, imem_ack, inst_valid, flush;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc;
  logic        zw_req, zw_valid, zw_flush;
  logic [31:0] zw_addr, zw_inst, zw_pc;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  fetch_sequencer #(.RESET_PC(32'h100), .ZERO_WAIT(1)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .pcsrc(pcsrc),
    .jr_target(jr_target), .jump_target(jump_target), .branch_target(branch_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .flush(flush)
  );

  // Second instance only used to observe the first-cycle ack being ignored.
  fetch_sequencer #(.RESET_PC(32'h100), .ZERO_WAIT(0)) dut_zw (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .pcsrc(pcsrc),
    .jr_target(jr_target), .jump_target(jump_target), .branch_target(branch_target),
    .stall(stall), .imem_req(zw_req), .imem_addr(zw_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(zw_valid), .inst(zw_inst), .inst_pc(zw_pc),
    .flush(zw_flush)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step into the BOOT cycle.
  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect_valid = 1'b0; pcsrc = 2'b11;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b1; stall = 1'b0;
    redirect_valid = 1'b1; pcsrc = 2'b00; jr_target = 32'h40;
    jump_target = 32'h0; branch_target = 32'h0;
    cyc();
    cyc();
    checks++; if (imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", imem_req); else passes++;
    checks++; if (imem_addr !== 32'h100) $display("[TB] FAIL reset_addr: got %h expected 00000100", imem_addr); else passes++;
    checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", inst_valid); else passes++;
    checks++; if (inst !== 32'h0) $display("[TB] FAIL reset_inst: got %h expected 00000000", inst); else passes++;
    checks++; if (inst_pc !== 32'h0) $display("[TB] FAIL reset_inst_pc: got %h expected 00000000", inst_pc); else passes++;
    checks++; if (flush !== 1'b0) $display("[TB] FAIL reset_flush: got %b expected 0", flush); else passes++;
    redirect_valid = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    imem_ack = 1'b1;
    checks++; if (imem_req !== 1'b0) $display("[TB] FAIL boot_req: got %b expected 0", imem_req); else passes++;
    cyc();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("[TB] FAIL first_req: got %b/%h expected 1/00000100", imem_req, imem_addr); else passes++;
    cyc();
    checks++; if (zw_valid !== 1'b0 || zw_addr !== 32'h100) $display("[TB] FAIL zero_wait_ignore: got %b/%h expected 0/00000100", zw_valid, zw_addr); else passes++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h100 + 32'(4 * k) || inst !== ((32'h100 + 32'(4 * k)) ^ 32'hDEAD_0000) || imem_addr !== 32'h104 + 32'(4 * k))
        $display("[TB] FAIL seq_slot%0d: got %b/%h/%h addr %h expected 1/%h", k, inst_valid, inst_pc, inst, imem_addr, 32'h100 + 32'(4 * k));
      else passes++;
      if (k == 1) begin
        checks++; if (zw_valid !== 1'b1 || zw_pc !== 32'h100) $display("[TB] FAIL zero_wait_accept: got %b/%h expected 1/00000100", zw_valid, zw_pc); else passes++;
      end
      cyc();
    end
  endtask

  task automatic test_ack_delay();
    do_reset();
    imem_ack = 1'b1;
    cyc();
    cyc();
    imem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) imem_ack = 1'b1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) $display("[TB] FAIL hold_addr%0d: got %b/%h expected 1/00000104", k, imem_req, imem_addr); else passes++;
      if (k == 1) begin
        checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL hold_slot_clear: got %b expected 0", inst_valid); else passes++;
      end
      cyc();
    end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h104 || inst !== 32'hDEAD_0104) $display("[TB] FAIL delayed_slot: got %b/%h/%h expected 1/00000104/dead0104", inst_valid, inst_pc, inst); else passes++;
    imem_ack = 1'b0;
    cyc();
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'h108) $display("[TB] FAIL no_duplicate: got %b/%h expected 0/00000108", inst_valid, imem_addr); else passes++;
  endtask

  task automatic test_stall();
    int acks;
    acks = 0;
    do_reset();
    imem_ack = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (imem_req && imem_ack) acks++;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h108 || inst !== 32'hDEAD_0108) $display("[TB] FAIL stall_hold%0d: got %b/%h/%h expected 1/00000108/dead0108", k, inst_valid, inst_pc, inst); else passes++;
      cyc();
    end
    stall = 1'b0;
    checks++; if (acks != 1) $display("[TB] FAIL stall_acks: got %0d expected 1", acks); else passes++;
    for (int k = 0; k < 3; k++) begin
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h108 + 32'(4 * k)) $display("[TB] FAIL stall_order%0d: got %b/%h expected 1/%h", k, inst_valid, inst_pc, 32'h108 + 32'(4 * k)); else passes++;
      cyc();
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    imem_ack = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    imem_ack = 1'b0; redirect_valid = 1'b1; pcsrc = 2'b10; branch_target = 32'h203;
    #1;
    checks++; if (flush !== 1'b1 || imem_addr !== 32'h10C) $display("[TB] FAIL drain_flush: got %b/%h expected 1/0000010c", flush, imem_addr); else passes++;
    cyc();
    redirect_valid = 1'b0;
    #1;
    checks++; if (flush !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10C || inst_valid !== 1'b0) $display("[TB] FAIL drain_hold: got %b/%b/%h/%b expected 0/1/0000010c/0", flush, imem_req, imem_addr, inst_valid); else passes++;
    imem_ack = 1'b1;
    cyc();
    checks++; if (imem_addr !== 32'h200 || inst_valid !== 1'b0) $display("[TB] FAIL drain_target: got %h/%b expected 00000200/0", imem_addr, inst_valid); else passes++;
    cyc();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== 32'hDEAD_0200) $display("[TB] FAIL drain_slot: got %b/%h/%h expected 1/00000200/dead0200", inst_valid, inst_pc, inst); else passes++;
  endtask

  task automatic test_redirect_twice();
    do_reset();
    imem_ack = 1'b1;
    cyc(); cyc();
    redirect_valid = 1'b1; pcsrc = 2'b11;
    #1;
    checks++; if (flush !== 1'b0) $display("[TB] FAIL noop_flush: got %b expected 0", flush); else passes++;
    cyc();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h104 || imem_addr !== 32'h108) $display("[TB] FAIL noop_seq: got %b/%h/%h expected 1/00000104/00000108", inst_valid, inst_pc, imem_addr); else passes++;
    imem_ack = 1'b0; redirect_valid = 1'b1; pcsrc = 2'b00; jr_target = 32'h500;
    #1;
    checks++; if (flush !== 1'b1) $display("[TB] FAIL twice_flush1: got %b expected 1", flush); else passes++;
    cyc();
    pcsrc = 2'b01; jump_target = 32'h3F2;
    #1;
    checks++; if (flush !== 1'b1 || imem_addr !== 32'h108) $display("[TB] FAIL twice_flush2: got %b/%h expected 1/00000108", flush, imem_addr); else passes++;
    cyc();
    redirect_valid = 1'b0; imem_ack = 1'b1;
    cyc();
    checks++; if (imem_addr !== 32'h3F0 || inst_valid !== 1'b0) $display("[TB] FAIL twice_target: got %h/%b expected 000003f0/0", imem_addr, inst_valid); else passes++;
    cyc();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3F0) $display("[TB] FAIL twice_slot: got %b/%h expected 1/000003f0", inst_valid, inst_pc); else passes++;
  endtask

  task automatic test_redirect_ack();
    do_reset();
    imem_ack = 1'b1;
    cyc(); cyc();
    redirect_valid = 1'b1; pcsrc = 2'b10; branch_target = 32'h600;
    #1;
    checks++; if (flush !== 1'b1) $display("[TB] FAIL ackredir_flush: got %b expected 1", flush); else passes++;
    cyc();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h600 || inst_valid !== 1'b0 || imem_req !== 1'b1) $display("[TB] FAIL ackredir_target: got %h/%b/%b expected 00000600/0/1", imem_addr, inst_valid, imem_req); else passes++;
    cyc();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h600) $display("[TB] FAIL ackredir_slot: got %b/%h expected 1/00000600", inst_valid, inst_pc); else passes++;
  endtask

  task automatic test_delay_slot();
    int flushes;
    flushes = 0;
    do_reset();
    imem_ack = 1'b1;
    cyc(); cyc();
    redirect_valid = 1'b1; pcsrc = 2'b01; jump_target = 32'h400;
    #1;
    if (flush) flushes++;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) $display("[TB] FAIL ds_slot0: got %b/%h expected 1/00000100", inst_valid, inst_pc); else passes++;
    cyc();
    redirect_valid = 1'b0;
    if (flush) flushes++;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h104 || imem_addr !== 32'h400) $display("[TB] FAIL ds_slot1: got %b/%h/%h expected 1/00000104/00000400", inst_valid, inst_pc, imem_addr); else passes++;
    cyc();
    if (flush) flushes++;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h400) $display("[TB] FAIL ds_slot2: got %b/%h expected 1/00000400", inst_valid, inst_pc); else passes++;
    checks++; if (flushes != 0) $display("[TB] FAIL ds_flush: got %0d expected 0", flushes); else passes++;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    imem_ack = 1'b1;
    cyc(); cyc();
    redirect_valid = 1'b1; pcsrc = 2'b00; jr_target = 32'hFFFF_FFFF;
    cyc();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_top: got %h expected fffffffc", imem_addr); else passes++;
    cyc();
    checks++; if (imem_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_zero: got %h/%h expected 00000000/fffffffc", imem_addr, inst_pc); else passes++;
    stall = 1'b1;
    cyc();
    checks++; if (imem_req !== 1'b0 || inst_pc !== 32'hFFFF_FFFC) $display("[TB] FAIL wait_state: got %b/%h expected 0/fffffffc", imem_req, inst_pc); else passes++;
    reset = 1'b1;
    cyc();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100 || inst_valid !== 1'b0 || inst_pc !== 32'h0) $display("[TB] FAIL wait_reset: got %b/%h/%b/%h expected 0/00000100/0/00000000", imem_req, imem_addr, inst_valid, inst_pc); else passes++;
    reset = 1'b0; stall = 1'b0;
  endtask

  initial begin
    $display("[TB] fetch_sequencer directed test start");
    test_reset();
    test_sequential();
    test_ack_delay();
    test_stall();
`ifdef FETCH_DELAY_SLOT_EN
    test_delay_slot();
`else
    test_redirect_drain();
    test_redirect_twice();
    test_redirect_ack();
`endif
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: ZERO_WAIT, 1, 1 = an ack in the same cycle as a newly raised req is accepted; 0 = acks are ignored in the cycle req first rises.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 redirect_valid  input  1  qualifies pcsrc for this cycle.
REQ-006 pcsrc  input  2  branch-unit PC select: 00 JR, 01 J/JAL, 10 branch taken, 11 sequential.
REQ-007 jr_target / jump_target / branch_target  input  32 each  redirect targets for codes 00/01/10.
REQ-008 stall  input  1  downstream cannot accept the instruction slot this cycle.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  request address, word aligned.
REQ-011 imem_ack  input  1  request accepted, imem_rdata valid this cycle.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 inst_valid / inst / inst_pc  output  1/32/32  single-entry instruction slot to decode.
REQ-014 flush  output  1  one-cycle pulse: younger instructions killed by a redirect.

Function
REQ-015 FSM states BOOT, REQ, WAIT, DRAIN; BOOT lasts exactly one cycle after reset deassertion, then REQ.
REQ-016 REQ: imem_req=1, imem_addr=pc; entered only if slot empty or consumed this cycle (inst_valid=0 or stall=0).
REQ-017 Ack in REQ/WAIT: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1 next cycle, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); go REQ if slot will be free, else WAIT with imem_req=0.
REQ-018 Once imem_req is raised for an address it SHALL stay high, with imem_addr stable, until imem_ack.
REQ-019 Slot holds inst/inst_pc unchanged while stall=1; clears (inst_valid<=0) when stall=0 and no new ack.
REQ-020 Redirect = redirect_valid=1 and pcsrc!=11; pc<=selected target with bits[1:0] forced 0; redirect_valid with pcsrc=11 is a no-op.
REQ-021 Redirect with no request outstanding: flush=1 for that cycle, inst_valid<=0, fetch of target starts next cycle.
REQ-022 Redirect while request outstanding and unacked: flush=1, enter DRAIN keeping the request; on ack discard data, go REQ at target.
REQ-023 Redirect in same cycle as ack: ack data discarded, no DRAIN, target fetched next cycle.
REQ-024 Second redirect during DRAIN overwrites pending target; flush pulses again.
REQ-025 Priority: reset > redirect > ack > stall.
REQ-026 Fetch latency: slot valid one cycle after ack; best case one instruction per cycle with ZERO_WAIT=1.

Reset
REQ-027 While reset=1: state=BOOT, pc=RESET_PC, imem_req=0, inst_valid=0, inst=0, inst_pc=0, flush=0, pending redirect cleared; an outstanding ack is ignored.
REQ-028 Reset mid-request abandons it; memory must tolerate a dropped req.

Configuration
REQ-029 Macro FETCH_DELAY_SLOT_EN defined: the instruction at branch_pc+4 (in slot or in flight) is kept and delivered; redirect applies to the following fetch; flush stays 0.
REQ-030 Macro undefined: REQ-021..REQ-024 apply; no delay slot.

Verification
REQ-031 Reset, RESET_PC=0x100, ack every cycle, stall=0 -> addrs 0x100,0x104,0x108; inst_valid continuous from cycle 3.
REQ-032 Ack delayed 3 cycles at 0x104 -> imem_req/imem_addr held stable 0x104 for all 4 cycles, no duplicate slot entry.
REQ-033 stall=1 for 4 cycles with slot=0x108 -> inst/inst_pc frozen; at most one ack absorbed; order preserved after release.
REQ-034 pcsrc=10, branch_target=0x203 during outstanding fetch of 0x10C -> flush 1 cycle, 0x10C data discarded, next imem_addr=0x200.
REQ-035 pc=0xFFFF_FFFC sequential -> next imem_addr=0x0; reset asserted in WAIT -> imem_req=0 next cycle, pc=RESET_PC.
REQ-036 With FETCH_DELAY_SLOT_EN, JAL at 0x100 target 0x400 -> slot sequence 0x100,0x104,0x400; flush never 1.
